// File: rtl/lsu_pass_ctrl.sv
// Pass sequencer for the LSU frame buffer: load one frame, run num_iters
// read-modify-write passes through the pixel pipeline, then stream the frame out.
module lsu_pass_ctrl #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int PIPE_LATENCY    = 4,
    parameter int ITER_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] num_iters,
    output logic                  busy,
    output logic                  done,
    output logic [ITER_WIDTH-1:0] pass_idx,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  wr_sel,
    output logic                  lsu_read_enable,
    output logic                  lsu_write_enable,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    localparam int BEATS = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [ITER_WIDTH-1:0] ITER_ONE = ITER_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        OUT,
        DONE
    } state_t;

    state_t                  state_reg;
    logic [ITER_WIDTH-1:0]   iters_left_reg;
    logic [ITER_WIDTH-1:0]   pass_idx_reg;
    logic [CNT_W-1:0]        rd_cnt_reg;
    logic [CNT_W-1:0]        wr_cnt_reg;
    logic [PIPE_LATENCY-1:0] vld_sr_reg;
    logic [PIPE_LATENCY-1:0] vld_sr_next;
    logic                    m_valid_reg;

    logic rd_room;
    logic iter_rd;
    logic out_rd;
    logic load_wr;
    logic iter_wr;
    logic wr_last;
    logic last_beat;
    logic out_hs;

    assign rd_room   = (rd_cnt_reg < BEATS_C);
    assign iter_rd   = (state_reg == ITER) && rd_room;
    // Only advance the output read when the held beat is free or being consumed.
    assign out_rd    = (state_reg == OUT) && rd_room && (!m_valid_reg || m_ready);
    assign load_wr   = (state_reg == LOAD) && s_valid;
    assign iter_wr   = (state_reg == ITER) && vld_sr_reg[PIPE_LATENCY-1];
    assign wr_last   = (wr_cnt_reg == LAST_C);
    assign last_beat = m_valid_reg && (rd_cnt_reg == BEATS_C);
    assign out_hs    = (state_reg == OUT) && m_valid_reg && m_ready && last_beat;

    // Valid tracker mirroring the pipeline: stage 0 takes the ITER read strobe.
    generate
        for (genvar gi = 0; gi < PIPE_LATENCY; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                assign vld_sr_next[gi] = iter_rd;
            end else begin : g_body
                assign vld_sr_next[gi] = vld_sr_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            vld_sr_reg <= '0;
        end else begin
            vld_sr_reg <= vld_sr_next;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg      <= IDLE;
            iters_left_reg <= '0;
            pass_idx_reg   <= '0;
            rd_cnt_reg     <= '0;
            wr_cnt_reg     <= '0;
            m_valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        iters_left_reg <= num_iters;
                        pass_idx_reg   <= '0;
                        rd_cnt_reg     <= '0;
                        wr_cnt_reg     <= '0;
                        m_valid_reg    <= 1'b0;
                        state_reg      <= LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        if (wr_last) begin
                            wr_cnt_reg <= '0;
                            rd_cnt_reg <= '0;
                            state_reg  <= (iters_left_reg != '0) ? ITER : OUT;
                        end else begin
                            wr_cnt_reg <= wr_cnt_reg + ONE_C;
                        end
                    end
                end
                ITER: begin
                    if (iter_rd) begin
                        rd_cnt_reg <= rd_cnt_reg + ONE_C;
                    end
                    // The BEATS-th write closes the pass; all reads are long done by then.
                    if (iter_wr) begin
                        if (wr_last) begin
                            wr_cnt_reg     <= '0;
                            rd_cnt_reg     <= '0;
                            iters_left_reg <= iters_left_reg - ITER_ONE;
                            pass_idx_reg   <= pass_idx_reg + ITER_ONE;
                            state_reg      <= (iters_left_reg > ITER_ONE) ? ITER : OUT;
                        end else begin
                            wr_cnt_reg <= wr_cnt_reg + ONE_C;
                        end
                    end
                end
                OUT: begin
                    if (out_rd) begin
                        rd_cnt_reg  <= rd_cnt_reg + ONE_C;
                        m_valid_reg <= 1'b1;
                    end else if (m_ready) begin
                        m_valid_reg <= 1'b0;
                    end
                    if (out_hs) begin
                        rd_cnt_reg  <= '0;
                        m_valid_reg <= 1'b0;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy             = (state_reg == LOAD) || (state_reg == ITER) || (state_reg == OUT);
    assign done             = (state_reg == DONE);
    assign s_ready          = (state_reg == LOAD);
    assign wr_sel           = (state_reg == ITER);
    assign lsu_read_enable  = iter_rd || out_rd;
    assign lsu_write_enable = load_wr || iter_wr;
    assign m_valid          = m_valid_reg;
    assign m_last           = last_beat;
    assign pass_idx         = pass_idx_reg;

endmodule

// File: doc/lsu_pass_ctrl.md
# lsu_pass_ctrl

Sequencing controller for the LSU frame buffer. It runs a frame through three kinds of pass:
- **Load:** accept one frame from the input stream and write it into the LSU.
- **Iterate:** run `num_iters` passes, each reading every beat from the LSU through the fixed-latency pixel pipeline and writing the result back.
- **Output:** stream the final frame out with a ready/valid handshake.

It owns the LSU's `read_enable`, `write_enable` and write-data select; pixel data never passes through this block.

## Interface
- PIXELS_PER_BEAT, 16, pixels per LSU word
- IMAGE_DIM, 512, frame is IMAGE_DIM x IMAGE_DIM pixels
- PIPE_LATENCY, 4, cycles from `lsu_read_enable` to the pipeline result being valid at the LSU write port (≥1)
- ITER_WIDTH, 8, width of iteration count
- Derived: BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT; CNT_W = $clog2(BEATS)+1
- Ports:
  - clk  in  1  single clock, rising edge
  - areset  in  1  asynchronous, active-high reset
  - start  in  1  begin a job; sampled only in IDLE
  - num_iters  in  ITER_WIDTH  iterate-pass count; captured when `start` is accepted
  - busy  out  1  high from the cycle after `start` is accepted until DONE
  - done  out  1  one-cycle pulse at job end
  - pass_idx  out  ITER_WIDTH  index of the current iterate pass (0-based), for pipeline configuration
  - s_valid  in  1  input beat valid
  - s_ready  out  1  input beat accepted when s_valid & s_ready
  - wr_sel  out  1  LSU write-data mux: 0 = input stream, 1 = pipeline result
  - lsu_read_enable  out  1  LSU read strobe
  - lsu_write_enable  out  1  LSU write strobe
  - m_valid  out  1  LSU read_data holds an unconsumed output beat
  - m_ready  in  1  downstream accepts the beat
  - m_last  out  1  qualifies the final output beat

## Operation
- **States:** IDLE, LOAD, ITER, OUT, DONE.
- **IDLE:**
  - `start` captures `num_iters` into `iters_left`, clears counters and `pass_idx`, and moves to LOAD.
  - `start` in any other state is ignored.
- **LOAD:**
  - s_ready = 1; wr_sel = 0; lsu_write_enable = s_valid (combinational); wr_cnt increments per accepted beat.
  - After beat BEATS-1 is accepted: go to ITER if iters_left ≠ 0, else go to OUT.
- **ITER:**
  - wr_sel = 1.
  - lsu_read_enable = 1 while rd_cnt < BEATS (one read per cycle, no stalls).
  - A PIPE_LATENCY-deep valid shift register follows the reads; its tail drives lsu_write_enable and increments wr_cnt.
  - The pass ends on the cycle the BEATS-th write issues. On that cycle: iters_left decrements, pass_idx increments, and counters clear.
  - Next state: ITER again if iters_left (before decrement) > 1, else OUT.
  - The next pass's first read issues the cycle after the last write, so there is no read/write overlap across passes.
- **OUT:**
  - lsu_read_enable = (rd_cnt < BEATS) & (~m_valid | m_ready).
  - m_valid is set on a read and cleared on m_ready when no read issues. The LSU holds read_data while read_enable is low, so no beat is lost under backpressure.
  - m_last = m_valid & (rd_cnt == BEATS).
  - On m_valid & m_ready & m_last: go to DONE.
- **DONE:** done = 1 for one cycle; then IDLE.
- Every pass issues exactly BEATS reads (ITER/OUT) and BEATS writes (LOAD/ITER). LSU pointers therefore stay aligned modulo depth across passes; the pointer offset itself is LSU configuration.
- **Reset:**
  - All outputs are 0: busy, done, s_ready, wr_sel, lsu_read_enable, lsu_write_enable, m_valid, m_last, pass_idx.
  - State is IDLE and all counters and the shift register are cleared.
  - Reset asserted mid-job abandons the job immediately; any in-flight pipeline results are never written.

## Timing
- Accepted `start` at cycle t: state = LOAD and s_ready = 1 at t+1.
- ITER pass length = BEATS + PIPE_LATENCY cycles. Read k issues at pass cycle k; write k issues at pass cycle k+PIPE_LATENCY.
- OUT: the first m_valid appears one cycle after the first read. With m_ready held high, one beat is delivered per cycle.
- done pulses the cycle after the m_last handshake; busy drops in the same cycle.
- Counters never exceed BEATS. rd_cnt saturates, so no read issues once it reaches BEATS.

## Test plan
- **Load timing:** IMAGE_DIM=8, PIXELS_PER_BEAT=16 (BEATS=4), PIPE_LATENCY=2, num_iters=0, continuous s_valid, m_ready=1 -> exactly 4 write strobes with wr_sel=0, then 4 reads, m_last on the 4th beat, done 1 cycle later.
- **Iterate timing:** num_iters=2 -> each ITER pass lasts 6 cycles with reads at pass cycles 0..3 and writes at 2..5; pass_idx goes 0→1→2; total of 8 read/write pairs before OUT.
- **Input gaps:** s_valid toggling 1,0,0,1,... in LOAD -> lsu_write_enable only on handshake cycles; the LOAD→ITER transition occurs exactly after the 4th accepted beat.
- **Output backpressure:** m_ready low for 3 cycles mid-OUT -> m_valid holds, no extra reads, and the beat sequence is intact (4 reads, 4 handshakes).
- **Mid-job reset:** assert areset during an ITER pass -> all outputs 0 asynchronously, no further strobes; a new `start` runs a full job correctly.
- **Start while busy:** `start` pulsed during OUT -> ignored; only one done pulse occurs.
